// File: rtl/a8_bus_capture.sv
// a8_bus_capture: synchronises the Atari 8-bit bus, rebuilds PHI2 cycles and queues window writes in a FIFO.
module a8_bus_capture #(
   parameter logic [7:0] WIN_PAGE   = 8'hD1,
   parameter int         FIFO_DEPTH = 8,
   parameter int         MIN_HIGH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a8_clk,
   input  logic [15:0] a8_addr,
   input  logic [7:0]  a8_data,
   input  logic        a8_rw_n,
   input  logic        a8_ref_n,
   input  logic        a8_rst_n,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_addr,
   output logic [7:0]  out_data,
   output logic [4:0]  fifo_level,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic [15:0] cycle_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = $clog2(MIN_HIGH + 1);
   localparam logic [HW-1:0] MIN_HC = HW'(MIN_HIGH);
   localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

   logic [27:0]   r_sync1, r_sync2;
   logic [25:0]   r_snap;
   logic          r_phi_d;
   logic [HW-1:0] r_high_cnt;
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [4:0]    r_level;
   logic          r_ovf;
   logic [15:0]   r_cnt;

   logic          w_phi_s, w_rst_s_n, w_fall, w_qual, w_push_req, w_full, w_pop, w_push, w_drop;

   assign w_phi_s   = r_sync2[27];
   assign w_rst_s_n = r_sync2[0];
   // r_high_cnt already includes the last high cycle, so a pulse of exactly MIN_HIGH clocks qualifies
   assign w_fall     = r_phi_d & ~w_phi_s & (r_high_cnt >= MIN_HC);
   assign w_qual     = w_fall & r_snap[0];
   assign w_push_req = w_qual & ~r_snap[1] & (r_snap[25:18] == WIN_PAGE) & w_rst_s_n;
   assign w_full     = r_level == DEPTH_L;
   assign out_valid  = r_level != 5'd0;
   assign w_pop      = out_valid & out_ready;
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & w_full & ~w_pop;

   assign out_addr   = r_mem[r_rptr][15:8];
   assign out_data   = r_mem[r_rptr][7:0];
   assign fifo_level = r_level;
   assign overflow   = r_ovf;
   assign cycle_cnt  = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_snap     <= '0;
         r_phi_d    <= 1'b0;
         r_high_cnt <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_sync1    <= {a8_clk, a8_addr, a8_data, a8_rw_n, a8_ref_n, a8_rst_n};
         r_sync2    <= r_sync1;
         r_phi_d    <= w_phi_s;
         r_high_cnt <= !w_phi_s ? '0 : (r_high_cnt == MIN_HC) ? r_high_cnt : r_high_cnt + 1'b1;
         if (w_phi_s)
            r_snap <= r_sync2[26:1];
         if (w_qual)
            r_cnt <= r_cnt + 16'd1;
         if (w_drop)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   // Atari reset flushes the queue every cycle; stale memory contents are never exposed since out_valid drops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
      end else if (!w_rst_s_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {r_snap[17:10], r_snap[9:2]};
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         r_level <= r_level + {4'd0, w_push} - {4'd0, w_pop};
      end
   end
endmodule

// File: doc/a8_bus_capture.md
Name: a8_bus_capture

Overview:
- Front-end stage between the Atari 8-bit cartridge/expansion bus pins and the pixl core logic.
- Synchronises the asynchronous A8 bus (PHI2 on a8_clk, address, data, R/W, refresh) into the FPGA clock domain and reconstructs complete bus cycles.
- Queues every CPU write that hits a configurable I/O page in a small FIFO, which the register/command logic drains through a valid/ready handshake.
- Also keeps a free-running PHI2 cycle count for timing-sensitive consumers.

Parameters:
- WIN_PAGE, 8'hD1, high address byte of the captured write window (0xD100-0xD1FF).
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..16.
- MIN_HIGH, 2, minimum consecutive clk cycles PHI2 must be seen high before its fall counts as a bus cycle (glitch filter).

Ports:
- clk  in  1  FPGA system clock; must be at least 8x PHI2 (1.79 MHz).
- rst  in  1  synchronous active-high reset.
- a8_clk  in  1  Atari PHI2; asynchronous to clk.
- a8_addr  in  16  Atari address bus.
- a8_data  in  8  Atari data bus.
- a8_rw_n  in  1  1 = read, 0 = write.
- a8_ref_n  in  1  0 = refresh cycle.
- a8_rst_n  in  1  Atari system reset, active low.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  8  low address byte of head entry.
- out_data  out  8  data byte of head entry.
- fifo_level  out  5  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: a qualifying write was dropped.
- ovf_clr  in  1  clears overflow.
- cycle_cnt  out  16  count of qualified PHI2 cycles; wraps.

Behaviour:
- Synchronisation:
  - a8_clk, a8_addr, a8_data, a8_rw_n, a8_ref_n and a8_rst_n each pass through an identical 2-flop synchroniser, so all bus signals stay mutually aligned.
  - Only the synchronised versions are used below (suffix _s).
- PHI2 tracking:
  - high_cnt (saturating at MIN_HIGH) increments each clk while phi2_s=1 and is cleared while phi2_s=0.
  - While phi2_s=1, a snapshot register is loaded every clk with {addr_s, data_s, rw_s, ref_s}.
  - Fall event in cycle T: phi2_s=0 in T, phi2_s=1 in T-1, and high_cnt>=MIN_HIGH in T-1. A shorter high pulse is ignored entirely (no count, no push).
- Cycle qualification on a fall event:
  - If snapshot ref=0: refresh cycle; nothing happens (no count, no push).
  - Otherwise cycle_cnt increments by 1 at the end of cycle T, wrapping 0xFFFF to 0x0000.
  - Push request if snapshot rw=0 AND snapshot addr[15:8]==WIN_PAGE AND rst_s_n=1.
- FIFO:
  - Push writes {addr[7:0], data} at the end of cycle T. If the FIFO was empty, out_valid=1 in T+1 (fall-to-valid latency 1 clk, i.e. 3 clk from the raw PHI2 fall).
  - Pop occurs when out_valid & out_ready at a clk edge.
  - out_addr/out_data always show the head entry, are stable while out_valid=1 and out_ready=0, and are don't-care when out_valid=0.
  - Push and pop in the same cycle: both succeed and fifo_level is unchanged, including when the FIFO is full.
  - Push while full with no pop: the entry is dropped, overflow is set, and FIFO contents are unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Set by a drop; cleared by ovf_clr.
  - If a drop and ovf_clr happen in the same cycle, set wins.
- Atari reset:
  - While rst_s_n=0, the FIFO is flushed every cycle (level=0, out_valid=0) and no pushes occur.
  - cycle_cnt keeps counting; overflow is unaffected.
- rst (mid-operation included): on the next edge, the FIFO is emptied, and all of the following go to 0: overflow, cycle_cnt, high_cnt, snapshot and the synchroniser flops.
- Reset values: out_valid=0, out_addr=0, out_data=0, fifo_level=0, overflow=0, cycle_cnt=0.
- Reads and writes outside the window are counted but never queued. Data-bus drive and MPD generation are out of scope for this block.

Test Plan:
- Write 0x5A to 0xD123 (PHI2 high 8 clk) -> out_valid=1 exactly 1 clk after the synchronised fall; out_addr=0x23, out_data=0x5A; cycle_cnt=1; fifo_level=1.
- Reads from 0xD123, a write to 0xD223 and a refresh cycle with a8_ref_n=0 -> no FIFO entry. cycle_cnt advances by 2 (the two non-refresh cycles), not 3.
- A 1-clk PHI2 glitch followed by a valid write -> exactly one entry, and cycle_cnt increments by 1.
- 9 writes (data 0x01..0x09) with out_ready=0 -> fifo_level=8, overflow=1, and drained order is 0x01..0x08. Then pulse ovf_clr -> overflow=0.
- With the FIFO full, a write arrives in the same cycle as a pop -> level stays 8, no overflow, and the new entry is last.
- Pull a8_rst_n low with 3 entries queued -> level=0 and out_valid=0 within 3 clk; writes during reset are ignored. Assert rst mid-PHI2-high -> all outputs return to reset values, and the next full cycle is captured normally.
